// File: rtl/lmi_dcache_ramarb_if.sv
// Request/grant bundle between the dcache RAM arbiter and its three requesters.
// The master side drives requests and the slave side (the arbiter) drives grants.
interface lmi_dcache_ramarb_if #(
   parameter int unsigned BEAT_W = 2
);
   logic              pipe_req;
   logic              pipe_gnt;
   logic              arb_halt;
   logic              fill_req;
   logic              fill_gnt;
   logic [BEAT_W-1:0] fill_beat;
   logic              fill_done;
   logic              ext_dcreqram_r;
   logic              dc_gntram_r;
   logic [1:0]        ram_sel;

   modport master (
      output pipe_req, fill_req, ext_dcreqram_r,
      input  pipe_gnt, arb_halt, fill_gnt, fill_beat, fill_done, dc_gntram_r, ram_sel
   );

   modport slave (
      input  pipe_req, fill_req, ext_dcreqram_r,
      output pipe_gnt, arb_halt, fill_gnt, fill_beat, fill_done, dc_gntram_r, ram_sel
   );
endinterface

// File: rtl/lmi_dcache_ramarb.sv
// Fixed-priority arbiter for the dcache data/tag RAM port: pipeline > fill > external,
// with a starvation counter for the lower two and a hold limit on the external grant.
module lmi_dcache_ramarb #(
   parameter int unsigned BEAT_W       = 2,
   parameter int unsigned CNT_W        = 3,
   parameter int unsigned STARVE_LIMIT = 7,
   parameter int unsigned HOLD_W       = 4,
   parameter int unsigned EXT_MAX_HOLD = 15
) (
   input logic                 clk,
   input logic                 reset_d1_r,
   lmi_dcache_ramarb_if.slave  bus
);

   typedef enum logic [1:0] {StIdle, StFill, StExt} state_e;

   localparam logic [BEAT_W-1:0] LastBeat  = '1;
   localparam logic [CNT_W-1:0]  StarveMax = CNT_W'(STARVE_LIMIT);
   localparam logic [HOLD_W-1:0] HoldMax   = HOLD_W'(EXT_MAX_HOLD);

   state_e            state_q, state_d;
   logic [CNT_W-1:0]  starve_q, starve_d;
   logic [HOLD_W-1:0] hold_q, hold_d;
   logic [BEAT_W-1:0] beat_q, beat_d;
   logic              pipe_gnt_c;
   logic [1:0]        sel_c;
   logic              starve_hit;

   assign starve_hit = (starve_q == StarveMax);

   always_ff @(posedge clk) begin
      if (reset_d1_r) begin
         state_q  <= StIdle;
         starve_q <= '0;
         hold_q   <= '0;
         beat_q   <= '0;
      end else begin
         state_q  <= state_d;
         starve_q <= starve_d;
         hold_q   <= hold_d;
         beat_q   <= beat_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      starve_d   = starve_q;
      hold_d     = hold_q;
      beat_d     = beat_q;
      pipe_gnt_c = 1'b0;
      sel_c      = 2'b00;
      unique case (state_q)
         StIdle: begin
            pipe_gnt_c = bus.pipe_req;
            sel_c      = bus.pipe_req ? 2'b01 : 2'b00;
            if (bus.fill_req && (!bus.pipe_req || starve_hit)) begin
               state_d  = StFill;
               beat_d   = '0;
               starve_d = '0;
            end else if (bus.ext_dcreqram_r && (!bus.pipe_req || starve_hit)) begin
               state_d  = StExt;
               hold_d   = '0;
               starve_d = '0;
            end else if ((bus.fill_req || bus.ext_dcreqram_r) && bus.pipe_req) begin
               if (!starve_hit) starve_d = starve_q + CNT_W'(1);
            end else begin
               starve_d = '0;
            end
         end
         StFill: begin
            sel_c = 2'b10;
            // A burst always runs to its last beat, even if fill_req drops.
            if (beat_q == LastBeat) begin
               state_d = StIdle;
               beat_d  = '0;
            end else begin
               beat_d = beat_q + BEAT_W'(1);
            end
         end
         StExt: begin
            sel_c = 2'b11;
            if (hold_q != '1) hold_d = hold_q + HOLD_W'(1);
            if (!bus.ext_dcreqram_r ||
                ((hold_q == HoldMax) && (bus.pipe_req || bus.fill_req))) begin
               state_d = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   // Combinational outputs are gated during reset; registered ones follow the state.
   assign bus.pipe_gnt    = pipe_gnt_c & ~reset_d1_r;
   assign bus.arb_halt    = bus.pipe_req & ~pipe_gnt_c & ~reset_d1_r;
   assign bus.ram_sel     = reset_d1_r ? 2'b00 : sel_c;
   assign bus.fill_gnt    = (state_q == StFill);
   assign bus.fill_beat   = beat_q;
   assign bus.fill_done   = (state_q == StFill) && (beat_q == LastBeat);
   assign bus.dc_gntram_r = (state_q == StExt);

endmodule

// File: tb/tb_lmi_dcache_ramarb.sv
// Vector-table bench for the dcache RAM arbiter; each row is one clock cycle and its
// expected outputs go through a scoreboard queue before being compared at the negedge.
module tb_lmi_dcache_ramarb;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   lmi_dcache_ramarb_if #(.BEAT_W(2)) bus ();

   lmi_dcache_ramarb #(
      .BEAT_W      (2),
      .CNT_W       (3),
      .STARVE_LIMIT(7),
      .HOLD_W      (4),
      .EXT_MAX_HOLD(15)
   ) dut (
      .clk       (clk),
      .reset_d1_r(rst),
      .bus       (bus)
   );

   typedef struct {
      logic       r;
      logic       p;
      logic       f;
      logic       x;
      logic [8:0] ex;
   } vec_t;

   vec_t       vecs[$];
   logic [8:0] sb_q[$];
   int         tests = 0;
   int         fails = 0;

   // Packed expectation: {pipe_gnt, arb_halt, fill_gnt, fill_beat[1:0], fill_done, dc_gnt, sel}
   function automatic logic [8:0] e(bit pg, bit h, bit fg, int beat, bit d, bit dg, int sel);
      logic [1:0] b;
      logic [1:0] s;
      b = beat[1:0];
      s = sel[1:0];
      return {pg, h, fg, b, d, dg, s};
   endfunction

   function automatic void add(bit r, bit p, bit f, bit x, logic [8:0] ex);
      vec_t v;
      v.r = r; v.p = p; v.f = f; v.x = x; v.ex = ex;
      vecs.push_back(v);
   endfunction

   task automatic step(input bit r, input bit p, input bit f, input bit x,
                       input logic [8:0] ex, input string name);
      logic [8:0] act;
      logic [8:0] want;
      rst                = r;
      bus.pipe_req       = p;
      bus.fill_req       = f;
      bus.ext_dcreqram_r = x;
      sb_q.push_back(ex);
      @(negedge clk);
      act  = {bus.pipe_gnt, bus.arb_halt, bus.fill_gnt, bus.fill_beat, bus.fill_done,
              bus.dc_gntram_r, bus.ram_sel};
      want = sb_q.pop_front();
      tests++;
      if (act !== want) begin
         fails++;
         $display("FAIL %s: got pg=%b halt=%b fg=%b beat=%0d done=%b dcg=%b sel=%b, want pg=%b halt=%b fg=%b beat=%0d done=%b dcg=%b sel=%b",
                  name, act[8], act[7], act[6], act[5:4], act[3], act[2], act[1:0],
                  want[8], want[7], want[6], want[5:4], want[3], want[2], want[1:0]);
      end
      @(posedge clk);
      #1;
   endtask

   logic [8:0] idle0, pipeg, extg, exth;

   initial begin
      idle0 = e(0, 0, 0, 0, 0, 0, 0);
      pipeg = e(1, 0, 0, 0, 0, 0, 1);
      extg  = e(0, 0, 0, 0, 0, 1, 3);
      exth  = e(0, 1, 0, 0, 0, 1, 3);

      // Reset held: pipe grant gated off.
      add(1, 1, 0, 0, idle0);
      // Simple pipe accesses.
      for (int i = 0; i < 3; i++) add(0, 1, 0, 0, pipeg);
      add(0, 0, 0, 0, idle0);
      // Fill burst with the pipe idle.
      add(0, 0, 1, 0, idle0);
      for (int k = 0; k < 4; k++) add(0, 0, 1, 0, e(0, 0, 1, k, k == 3, 0, 2));
      add(0, 0, 0, 0, idle0);
      // Fill starvation under continuous pipe traffic.
      for (int i = 0; i < 8; i++) add(0, 1, 1, 0, pipeg);
      for (int k = 0; k < 4; k++) add(0, 1, 1, 0, e(0, 1, 1, k, k == 3, 0, 2));
      add(0, 1, 0, 0, pipeg);
      add(0, 0, 0, 0, idle0);
      // External tenure of five request cycles.
      add(0, 0, 0, 1, idle0);
      for (int i = 0; i < 4; i++) add(0, 0, 0, 1, extg);
      add(0, 0, 0, 0, extg);
      add(0, 0, 0, 0, idle0);
      // Simultaneous fill+ext: fill wins, fill_req dropped mid-burst is ignored.
      add(0, 0, 1, 1, idle0);
      add(0, 0, 1, 1, e(0, 0, 1, 0, 0, 0, 2));
      for (int k = 1; k < 4; k++) add(0, 0, 0, 1, e(0, 0, 1, k, k == 3, 0, 2));
      add(0, 0, 0, 1, idle0);
      add(0, 0, 0, 0, extg);
      add(0, 0, 0, 0, idle0);
      // Reset mid-burst on beat 1: no done, back to idle with beat 0.
      add(0, 0, 1, 0, idle0);
      add(0, 0, 1, 0, e(0, 0, 1, 0, 0, 0, 2));
      add(1, 0, 1, 0, e(0, 0, 1, 1, 0, 0, 0));
      add(0, 0, 0, 0, idle0);
      add(0, 0, 0, 0, idle0);
      // Reset during EXT: grant drops the following cycle.
      add(0, 0, 0, 1, idle0);
      add(0, 0, 0, 1, extg);
      add(1, 0, 0, 1, e(0, 0, 0, 0, 0, 1, 0));
      add(0, 0, 0, 0, idle0);

      bus.pipe_req       = 1'b0;
      bus.fill_req       = 1'b0;
      bus.ext_dcreqram_r = 1'b0;
      repeat (2) @(posedge clk);
      #1;

      for (int i = 0; i < vecs.size(); i++)
         step(vecs[i].r, vecs[i].p, vecs[i].f, vecs[i].x, vecs[i].ex, $sformatf("vec%0d", i));

      // Revoke: pipe raised on grant cycle 3, grant lasts 16 EXT cycles.
      step(0, 0, 0, 1, idle0, "rev_req");
      for (int k = 0; k < 16; k++)
         step(0, k >= 2, 0, 1, (k >= 2) ? exth : extg, $sformatf("rev_ext%0d", k));
      step(0, 1, 0, 1, pipeg, "rev_pipe");
      step(0, 0, 0, 1, idle0, "rev_reidle");
      step(0, 0, 0, 0, extg, "rev_regnt");
      step(0, 0, 0, 0, idle0, "rev_end");

      // Long uncontested tenure; hold counter must saturate, not wrap.
      step(0, 0, 0, 1, idle0, "sat_req");
      for (int k = 0; k < 20; k++) step(0, 0, 0, 1, extg, $sformatf("sat_ext%0d", k));
      step(0, 1, 0, 1, exth, "sat_revoke");
      step(0, 1, 0, 0, pipeg, "sat_pipe");
      step(0, 0, 0, 0, idle0, "sat_end");

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
